// File: rtl/flash_read_seq.sv
// rtl/flash_read_seq.sv - autonomous SPI flash READ (0x03) sequencer with word buffer
// Drives a byte-level SPI core; bytes land little-endian in a CPU-readable buffer.
module flash_read_seq #(
  parameter int BUF_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sys_reg_select,
  input  logic        sys_buf_select,
  input  logic [7:0]  sys_addr,
  input  logic [3:0]  sys_we,
  input  logic        sys_rd,
  input  logic [31:0] sys_wdata,
  output logic [31:0] sys_rdata,
  output logic        irq,
  output logic        spi_we,
  output logic [7:0]  spi_di,
  input  logic [7:0]  spi_do,
  input  logic        spi_ready,
  output logic        spi_ss_reset
);
  localparam int AW = $clog2(BUF_WORDS);
  localparam int CW = $clog2(4 * BUF_WORDS) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CSRST, S_CMD, S_A2, S_A1, S_A0, S_DATA, S_FIN, S_ABORT
  } state_t;
  typedef enum logic [1:0] {P_ISSUE, P_GUARD, P_WAIT} phase_t;

  state_t        state, state_n;
  phase_t        phase, phase_n;
  logic          done, aborted, irq_en;
  logic [CW-1:0] count, xfer_len;
  logic [23:0]   addr_reg, xfer_addr;
  logic [7:0]    len_reg, tx_byte;
  logic          busy, ctrl_wr, start_req, abort_req, byte_done, store, last;
  logic [31:0]   status, reg_rd;
  logic [31:0]   buf_mem [BUF_WORDS];
  logic          unused_bits;

  assign unused_bits = ^{sys_we[3], sys_wdata[31:24]};

  assign busy      = (state != S_IDLE);
  assign ctrl_wr   = sys_reg_select && (sys_addr == 8'd0) && sys_we[0];
  assign start_req = ctrl_wr && sys_wdata[0] && !busy;
  // A second abort while the abort pulse is already going out would only repeat it
  assign abort_req = ctrl_wr && sys_wdata[1] && busy && (state != S_ABORT);
  assign last      = ((count + CW'(1)) == xfer_len);
  assign store     = byte_done && (state == S_DATA);
  assign irq       = done & irq_en;
  assign status    = 32'({count, 4'b0000, irq_en, aborted, done, busy});

  always_comb begin
    reg_rd = 32'h0;
    case (sys_addr)
      8'd0: reg_rd = status;
      8'd1: reg_rd = {8'h00, addr_reg};
      8'd2: reg_rd = {24'h0, len_reg};
      default: reg_rd = 32'h0;
    endcase
  end

  always_comb begin
    state_n      = state;
    phase_n      = phase;
    spi_we       = 1'b0;
    spi_di       = 8'h00;
    spi_ss_reset = 1'b0;
    byte_done    = 1'b0;
    case (state)
      S_CMD:   tx_byte = 8'h03;
      S_A2:    tx_byte = xfer_addr[23:16];
      S_A1:    tx_byte = xfer_addr[15:8];
      S_A0:    tx_byte = xfer_addr[7:0];
      default: tx_byte = 8'h00;
    endcase
    case (state)
      S_IDLE:  if (start_req) state_n = S_CSRST;
      S_CSRST: begin
        spi_ss_reset = 1'b1;
        state_n      = S_CMD;
        phase_n      = P_ISSUE;
      end
      S_FIN, S_ABORT: begin
        spi_ss_reset = 1'b1;
        state_n      = S_IDLE;
      end
      default: begin
        case (phase)
          P_ISSUE: if (spi_ready) begin
            spi_we  = 1'b1;
            spi_di  = tx_byte;
            phase_n = P_GUARD;
          end
          P_GUARD: phase_n = P_WAIT;
          default: if (spi_ready) begin
            byte_done = 1'b1;
            phase_n   = P_ISSUE;
            case (state)
              S_CMD:   state_n = S_A2;
              S_A2:    state_n = S_A1;
              S_A1:    state_n = S_A0;
              S_A0:    state_n = S_DATA;
              S_DATA:  if (last) state_n = S_FIN;
              default: state_n = state;
            endcase
          end
        endcase
      end
    endcase
    // Never launch a byte in the cycle an abort is being accepted
    if (abort_req) begin
      state_n = S_ABORT;
      spi_we  = 1'b0;
      spi_di  = 8'h00;
    end
    if (reset) begin
      spi_we       = 1'b0;
      spi_di       = 8'h00;
      spi_ss_reset = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      phase     <= P_ISSUE;
      done      <= 1'b0;
      aborted   <= 1'b0;
      irq_en    <= 1'b0;
      count     <= '0;
      xfer_len  <= '0;
      addr_reg  <= 24'h0;
      xfer_addr <= 24'h0;
      len_reg   <= 8'h00;
      sys_rdata <= 32'h0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      if (ctrl_wr) begin
        irq_en <= sys_wdata[3];
        if (sys_wdata[2]) begin
          done    <= 1'b0;
          aborted <= 1'b0;
        end
      end
      if (start_req) begin
        done      <= 1'b0;
        aborted   <= 1'b0;
        count     <= '0;
        xfer_addr <= addr_reg;
        xfer_len  <= (len_reg == 8'h00) ? CW'(4 * BUF_WORDS) : CW'(len_reg);
      end
      if (store) count <= count + CW'(1);
      // Completion wins over a simultaneous clear
      if (state == S_FIN)   done    <= 1'b1;
      if (state == S_ABORT) aborted <= 1'b1;
      if (sys_reg_select && !busy && (sys_addr == 8'd1)) begin
        if (sys_we[0]) addr_reg[7:0]   <= sys_wdata[7:0];
        if (sys_we[1]) addr_reg[15:8]  <= sys_wdata[15:8];
        if (sys_we[2]) addr_reg[23:16] <= sys_wdata[23:16];
      end
      if (sys_reg_select && !busy && (sys_addr == 8'd2) && sys_we[0])
        len_reg <= sys_wdata[7:0];
      if (sys_rd && sys_reg_select)
        sys_rdata <= reg_rd;
      else if (sys_rd && sys_buf_select)
        sys_rdata <= buf_mem[sys_addr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (store) buf_mem[count[AW+1:2]][8*count[1:0] +: 8] <= spi_do;
  end
endmodule

// File: tb/tb_flash_read_seq.sv
// tb/tb_flash_read_seq.sv - scoreboard bench for flash_read_seq with a behavioural SPI core
module tb_flash_read_seq;
  logic        clk, reset;
  logic        sys_reg_select, sys_buf_select, sys_rd;
  logic [7:0]  sys_addr;
  logic [3:0]  sys_we;
  logic [31:0] sys_wdata, sys_rdata;
  logic        irq, spi_we, spi_ready, spi_ss_reset;
  logic [7:0]  spi_di, spi_do;

  flash_read_seq #(.BUF_WORDS(64)) dut (
    .clk(clk), .reset(reset),
    .sys_reg_select(sys_reg_select), .sys_buf_select(sys_buf_select),
    .sys_addr(sys_addr), .sys_we(sys_we), .sys_rd(sys_rd),
    .sys_wdata(sys_wdata), .sys_rdata(sys_rdata), .irq(irq),
    .spi_we(spi_we), .spi_di(spi_di), .spi_do(spi_do),
    .spi_ready(spi_ready), .spi_ss_reset(spi_ss_reset)
  );

  int tests = 0;
  int fails = 0;
  int ss_count = 0;
  int data_ret = 0;
  int stall_k = -1;
  int stall_n = 0;
  logic [7:0]  pat [0:255];
  logic [7:0]  spi_q [$];
  logic [31:0] rd_q [$];
  string       rn_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Behavioural SPI core: 3-cycle shift, optional extra stall on one byte index
  initial begin : core_model
    int k;
    k = 0;
    spi_ready = 1'b1;
    spi_do = 8'h00;
    forever begin
      @(negedge clk);
      if (spi_ss_reset === 1'b1) k = 0;
      else if (spi_we === 1'b1) begin
        @(posedge clk);
        #1 spi_ready = 1'b0;
        repeat (3 + ((k == stall_k) ? stall_n : 0)) @(posedge clk);
        #1;
        spi_do = (k >= 4) ? pat[k-4] : 8'h00;
        if (k >= 4) data_ret++;
        k++;
        spi_ready = 1'b1;
      end
    end
  end

  initial begin : monitor
    logic rd_prev;
    logic [7:0] e;
    rd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (spi_we === 1'b1) begin
        if (spi_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spi_extra_we: spi_di=%02h with no byte expected", spi_di);
        end else begin
          e = spi_q.pop_front();
          chk("spi_di", {24'h0, spi_di}, {24'h0, e});
        end
        chk("spi_we_while_not_ready", {31'h0, spi_ready}, 32'h1);
      end
      if (spi_ss_reset === 1'b1) ss_count++;
      if (rd_prev && rd_q.size() != 0) chk(rn_q.pop_front(), sys_rdata, rd_q.pop_front());
      rd_prev = sys_rd && (sys_reg_select || sys_buf_select);
    end
  end

  task automatic wr(input logic [7:0] a, input logic [3:0] we, input logic [31:0] d);
    sys_reg_select = 1'b1;
    sys_addr = a;
    sys_we = we;
    sys_wdata = d;
    @(posedge clk);
    #1 sys_reg_select = 1'b0;
    sys_we = 4'h0;
  endtask

  task automatic rd(input logic bsel, input logic [7:0] a, input logic [31:0] exp, input string name);
    rd_q.push_back(exp);
    rn_q.push_back(name);
    sys_reg_select = !bsel;
    sys_buf_select = bsel;
    sys_addr = a;
    sys_rd = 1'b1;
    @(posedge clk);
    #1 sys_rd = 1'b0;
    sys_reg_select = 1'b0;
    sys_buf_select = 1'b0;
  endtask

  task automatic push_hdr(input logic [23:0] a, input int n);
    spi_q.push_back(8'h03);
    spi_q.push_back(a[23:16]);
    spi_q.push_back(a[15:8]);
    spi_q.push_back(a[7:0]);
    for (int i = 0; i < n; i++) spi_q.push_back(8'h00);
  endtask

  task automatic wait_ss(input int target, input string name);
    for (int i = 0; i < 6000 && ss_count < target; i++) begin
      @(posedge clk);
      #1;
    end
    chk(name, {31'h0, ss_count >= target}, 32'h1);
  endtask

  initial begin : stim
    int base;
    reset = 1'b1;
    sys_reg_select = 1'b0; sys_buf_select = 1'b0; sys_rd = 1'b0;
    sys_addr = 8'h0; sys_we = 4'h0; sys_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", sys_rdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_spi_we", {31'h0, spi_we}, 32'h0);
    chk("rst_ss_reset", {31'h0, spi_ss_reset}, 32'h0);
    chk("rst_spi_di", {24'h0, spi_di}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    rd(0, 8'd0, 32'h0, "rst_status");
    rd(0, 8'd1, 32'h0, "rst_addr");
    rd(0, 8'd2, 32'h0, "rst_len");

    // Basic read
    pat[0] = 8'hDE; pat[1] = 8'hAD; pat[2] = 8'hBE; pat[3] = 8'hEF;
    wr(8'd1, 4'b0111, 32'h0001_2345);
    wr(8'd2, 4'b0001, 32'h4);
    push_hdr(24'h012345, 4);
    base = ss_count;
    wr(8'd0, 4'b0001, 32'h1);
    rd(0, 8'd0, 32'h1, "t1_busy_status");
    wait_ss(base + 2, "t1_timeout");
    repeat (3) @(posedge clk);
    #1 chk("t1_ss_pulses", ss_count, base + 2);
    rd(0, 8'd0, 32'h402, "t1_status");
    rd(1, 8'd0, 32'hEFBEADDE, "t1_word0");
    chk("t1_spi_drained", spi_q.size(), 0);

    // Full length ramp
    for (int i = 0; i < 256; i++) pat[i] = 8'(i);
    wr(8'd1, 4'b0111, 32'h0);
    wr(8'd2, 4'b0001, 32'h0);
    push_hdr(24'h000000, 256);
    base = ss_count;
    wr(8'd0, 4'b0001, 32'h1);
    wait_ss(base + 2, "t2_timeout");
    rd(0, 8'd0, 32'h10002, "t2_status");
    rd(1, 8'd63, 32'hFFFEFDFC, "t2_word63");
    rd(1, 8'd0, 32'h03020100, "t2_word0");
    chk("t2_spi_drained", spi_q.size(), 0);

    // Interrupt and clear
    pat[0] = 8'h5A;
    wr(8'd1, 4'b0111, 32'h10);
    wr(8'd2, 4'b0001, 32'h1);
    push_hdr(24'h000010, 1);
    base = ss_count;
    wr(8'd0, 4'b0001, 32'h9);
    @(negedge clk);
    chk("t3_irq_low_at_start", {31'h0, irq}, 32'h0);
    wait_ss(base + 2, "t3_timeout");
    @(negedge clk);
    chk("t3_irq_high", {31'h0, irq}, 32'h1);
    @(posedge clk);
    #1 rd(0, 8'd0, 32'h10A, "t3_status_done");
    wr(8'd0, 4'b0001, 32'hC);
    @(negedge clk);
    chk("t3_irq_cleared", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1 rd(0, 8'd0, 32'h108, "t3_status_cleared");
    rd(1, 8'd0, 32'h0302015A, "t3_word0_partial");

    // Abort after five data bytes
    for (int i = 0; i < 16; i++) pat[i] = 8'h80 + 8'(i);
    wr(8'd1, 4'b0111, 32'h100);
    wr(8'd2, 4'b0001, 32'h10);
    push_hdr(24'h000100, 5);
    base = ss_count;
    begin : t4
      int rb;
      rb = data_ret;
      wr(8'd0, 4'b0001, 32'h1);
      for (int i = 0; i < 2000 && data_ret < rb + 5; i++) begin
        @(posedge clk);
        #1;
      end
      chk("t4_timeout", {31'h0, data_ret >= rb + 5}, 32'h1);
    end
    wr(8'd0, 4'b0001, 32'h2);
    repeat (30) @(posedge clk);
    #1 chk("t4_ss_pulses", ss_count, base + 2);
    rd(0, 8'd0, 32'h504, "t4_status");
    rd(1, 8'd1, 32'h07060584, "t4_word1");
    chk("t4_spi_drained", spi_q.size(), 0);
    wr(8'd0, 4'b0001, 32'h2);
    repeat (3) @(posedge clk);
    #1 rd(0, 8'd0, 32'h504, "t4_idle_abort_status");
    chk("t4_idle_abort_no_ss", ss_count, base + 2);

    // Busy protection
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33;
    wr(8'd1, 4'b0111, 32'h00ABCD);
    wr(8'd2, 4'b0001, 32'h3);
    push_hdr(24'h00ABCD, 3);
    base = ss_count;
    wr(8'd0, 4'b0001, 32'h1);
    repeat (10) @(posedge clk);
    #1 wr(8'd1, 4'b0111, 32'hFFFFFF);
    wr(8'd2, 4'b0001, 32'h10);
    wr(8'd0, 4'b0001, 32'h1);
    wait_ss(base + 2, "t5_timeout");
    rd(0, 8'd0, 32'h302, "t5_status");
    rd(0, 8'd1, 32'h00ABCD, "t5_addr_kept");
    rd(0, 8'd2, 32'h3, "t5_len_kept");
    rd(1, 8'd0, 32'h83332211, "t5_word0");
    chk("t5_spi_drained", spi_q.size(), 0);

    // Stalled core on the first data byte
    pat[0] = 8'hC3; pat[1] = 8'h3C;
    stall_k = 4;
    stall_n = 20;
    wr(8'd1, 4'b0111, 32'h42);
    wr(8'd2, 4'b0001, 32'h2);
    push_hdr(24'h000042, 2);
    base = ss_count;
    wr(8'd0, 4'b0001, 32'h1);
    wait_ss(base + 2, "t6_timeout");
    stall_k = -1;
    rd(0, 8'd0, 32'h202, "t6_status");
    rd(1, 8'd0, 32'h83333CC3, "t6_word0");
    repeat (3) @(posedge clk);
    #1 chk("t6_spi_drained", spi_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/flash_read_seq.md
# flash_read_seq

Autonomous read sequencer for the boot SPI flash. It owns the byte-level SPI core (`spicore`): given a 24-bit flash address and a byte count, it issues a standard READ (0x03) transaction and streams up to 256 bytes into an internal 64-word buffer that the CPU reads over the memory bus. Completion raises a level interrupt into the top-level interrupt OR. It replaces CPU-driven byte polling of the flash SPI register.

## Interface
Parameters:
- `BUF_WORDS`, 64: buffer depth in 32-bit words; the maximum transfer length is 4×`BUF_WORDS` bytes.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `sys_reg_select`  in  1  selects the register window.
- `sys_buf_select`  in  1  selects the buffer window.
- `sys_addr`  in  8  word address within the selected window (`mem_addr[9:2]`).
- `sys_we`  in  4  byte write mask.
- `sys_rd`  in  1  read strobe.
- `sys_wdata`  in  32  write data.
- `sys_rdata`  out  32  read data, registered.
- `irq`  out  1  interrupt; equals `done & irq_en`.
- `spi_we`  out  1  one-cycle pulse that starts a byte transfer on the core.
- `spi_di`  out  8  byte to shift out.
- `spi_do`  in  8  byte shifted in; valid while `spi_ready`=1 after a transfer.
- `spi_ready`  in  1  core idle / previous byte complete.
- `spi_ss_reset`  out  1  one-cycle pulse that deasserts flash chip select.

## Operation
Registers (`sys_reg_select`; word address = `sys_addr`):
- 0 CTRL/STATUS. Write with `sys_we[0]`: bit0 start, bit1 abort, bit2 clear done/aborted (W1C), bit3 irq_en (stored). Read: bit0 busy, bit1 done, bit2 aborted, bit3 irq_en, bits[16:8] bytes stored so far (0..256).
- 1 ADDR: flash address [23:0], byte-lane writable. Writes are ignored while busy.
- 2 LEN: bits[7:0]; 0 means 256 bytes. Writes are ignored while busy.
- Other register addresses read as 0.

The buffer window (`sys_buf_select`, `sys_addr[5:0]`) is read-only. Byte i of the transfer lands in word i[7:2], lane i[1:0] (little-endian). Unwritten bytes keep their previous contents. Buffer writes are ignored.

States:
- IDLE: start=1 clears done and aborted, zeroes the count, latches ADDR and LEN, and moves to CSRST.
- CSRST: pulse `spi_ss_reset` for one cycle, then go to CMD.
- CMD: send 0x03.
- A2: send ADDR[23:16].
- A1: send ADDR[15:8].
- A0: send ADDR[7:0].
- DATA: send 0x00 once per byte. After each completion, store `spi_do` and increment the count. Leave when count == length.
- FIN: pulse `spi_ss_reset`, set done, return to IDLE.

Byte handshake, used by every send state:
- ISSUE: wait for `spi_ready`=1, then drive `spi_di` and pulse `spi_we` for one cycle.
- GUARD: one cycle in which `spi_ready` is ignored.
- WAIT: wait for `spi_ready`=1. The byte is then complete.

Control rules:
- `busy` = state ≠ IDLE.
- Start while busy is ignored.
- Abort while busy: on the next cycle pulse `spi_ss_reset`, set aborted, go to IDLE, leave done clear; the count holds its last value.
- Abort in IDLE has no effect.
- Start and abort in the same write: abort wins if busy; otherwise start.
- A clear-done write in the same cycle that FIN sets done: done ends set.

## Timing
- Reset values: `sys_rdata`=0, `irq`=0, `spi_we`=0, `spi_ss_reset`=0, `spi_di`=0. State is IDLE; done, aborted, irq_en, count, ADDR and LEN are all 0. Buffer contents are not reset.
- Reset mid-transfer returns to IDLE within one cycle, with no `spi_ss_reset` pulse.
- Start is written in cycle T:
  - busy reads 1 from T+1.
  - `spi_ss_reset` pulses in T+1.
  - The first `spi_we` pulses no earlier than T+2.
- Bytes are back to back: the next ISSUE fires in the cycle after WAIT sees `spi_ready`. The sequencer adds at most 3 cycles per byte over the core's shift time.
- The buffer byte is written in the cycle after `spi_ready` returns. The count increments in that same cycle.
- done and `irq` assert in the cycle after the final FIN `spi_ss_reset` pulse.
- `sys_rdata` updates in the cycle after a cycle with `sys_rd`=1 and a select. It holds otherwise.
- A buffer read while busy returns current (possibly partial) contents.

## Test plan
- **Basic read.** ADDR=0x012345, LEN=4, start; the flash model returns DE AD BE EF.
  - `spi_di` sequence is 03 01 23 45 00 00 00 00.
  - Buffer word 0 = 0xEFBEADDE.
  - STATUS = 0x0402 (count 4, done).
  - One `spi_ss_reset` pulse before and one after the transaction.
- **Full length.** LEN=0 → 256 data bytes, ramp 0..255.
  - Word 63 = 0xFFFEFDFC; count field = 0x100.
- **Interrupt and clear.** irq_en=1, LEN=1.
  - `irq` rises once done is set.
  - Writing CTRL=0x0C drops `irq` the next cycle while irq_en stays 1.
- **Abort.** LEN=16; abort after 5 data bytes.
  - `spi_ss_reset` pulses; STATUS = 0x0504 (count 5, aborted).
  - No further `spi_we` pulses.
- **Busy protection.** During a transfer, write ADDR=0xFFFFFF and start.
  - The transfer completes with the original address and length; the ADDR readback is unchanged.
- **Stalled core.** Hold `spi_ready`=0 for 20 cycles after a pulse.
  - No new `spi_we` is issued; the sequence resumes correctly once `spi_ready` returns.
